// File: rtl/id_instr_queue.sv
// -----------------------------------------------------------------------------
// id_instr_queue
//   In-order circular instruction queue between fetch and the decode/rename
//   stage. Up to FETCH_WIDTH instructions are written per cycle at the tail;
//   up to ISSUE_WIDTH_MAX oldest entries are presented per cycle from the head.
//   A presented valid lane is consumed in the same cycle. There is no
//   fetch-to-issue bypass, so a new entry becomes visible one cycle after it
//   is written.
//
// Ports
//   clk_free_master  core clock
//   global_rst       synchronous active-high reset
//   flush            discards all queued entries and the same-cycle fetch group
//   fetch_val_if     per-lane fetch valid, contiguous from lane 0
//   fetch_instr_if   fetched instruction words, lane 0 oldest
//   fetch_pc_if      PC of each fetch lane
//   fetch_rdy        the queue has room for a full fetch group this cycle
//   issue_stall      downstream backpressure; no lane is presented while high
//   instr_val_id     per-lane valid towards decode/RAT
//   instr_id         presented instruction words, lane 0 oldest
//   pc_id            PC of each presented lane
//   iq_count         registered occupancy
//   iq_empty         occupancy is zero
// -----------------------------------------------------------------------------
module id_instr_queue #(
  parameter int IQ_DEPTH        = 16,
  parameter int FETCH_WIDTH     = 4,
  parameter int ISSUE_WIDTH_MAX = 2,
  parameter int DATA_LEN        = 32
) (
  input  logic                                clk_free_master,
  input  logic                                global_rst,
  input  logic                                flush,
  input  logic [FETCH_WIDTH-1:0]              fetch_val_if,
  input  logic [FETCH_WIDTH*DATA_LEN-1:0]     fetch_instr_if,
  input  logic [FETCH_WIDTH*DATA_LEN-1:0]     fetch_pc_if,
  output logic                                fetch_rdy,
  input  logic                                issue_stall,
  output logic [ISSUE_WIDTH_MAX-1:0]          instr_val_id,
  output logic [ISSUE_WIDTH_MAX*DATA_LEN-1:0] instr_id,
  output logic [ISSUE_WIDTH_MAX*DATA_LEN-1:0] pc_id,
  output logic [$clog2(IQ_DEPTH):0]           iq_count,
  output logic                                iq_empty
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;

  function automatic logic [CW-1:0] popcnt_fetch(input logic [FETCH_WIDTH-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) r = r + CW'(v[i]);
    return r;
  endfunction

  function automatic logic [CW-1:0] popcnt_issue(input logic [ISSUE_WIDTH_MAX-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < ISSUE_WIDTH_MAX; i++) r = r + CW'(v[i]);
    return r;
  endfunction

  logic [DATA_LEN-1:0] mem_instr [IQ_DEPTH];
  logic [DATA_LEN-1:0] mem_pc    [IQ_DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          fetch_contig;
  logic          enq;
  logic [CW-1:0] n_enq;
  logic [CW-1:0] n_deq;

  assign iq_count = count;
  assign iq_empty = (count == '0);

  // Room is judged from the registered count only, so a full group is always
  // guaranteed to fit regardless of what is dequeued this cycle.
  assign fetch_rdy = ~global_rst & ~flush & (count <= CW'(IQ_DEPTH - FETCH_WIDTH));

  // A contiguous-from-lane-0 mask has the form 2^k-1, so v & (v+1) is zero.
  assign fetch_contig = ((fetch_val_if & (fetch_val_if + FETCH_WIDTH'(1))) == '0);
  assign enq          = fetch_rdy & (|fetch_val_if) & fetch_contig;
  assign n_enq        = enq ? popcnt_fetch(fetch_val_if) : '0;

  always_comb begin
    instr_val_id = '0;
    instr_id     = '0;
    pc_id        = '0;
    for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
      instr_val_id[i] = (count > CW'(i)) & ~issue_stall & ~flush & ~global_rst;
      instr_id[i*DATA_LEN +: DATA_LEN] = mem_instr[head + PW'(i)];
      pc_id[i*DATA_LEN +: DATA_LEN]    = mem_pc[head + PW'(i)];
    end
  end

  assign n_deq = popcnt_issue(instr_val_id);

  // Queue control: reset and flush both empty the queue and drop any
  // same-cycle fetch group; otherwise pointers and count move together.
  always_ff @(posedge clk_free_master) begin
    if (global_rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(n_deq);
      tail  <= tail + PW'(n_enq);
      count <= count + n_enq - n_deq;
    end
  end

  // Storage write: lane i lands at tail+i, wrapping through the pointer width.
  always_ff @(posedge clk_free_master) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (enq && fetch_val_if[i]) begin
        mem_instr[tail + PW'(i)] <= fetch_instr_if[i*DATA_LEN +: DATA_LEN];
        mem_pc[tail + PW'(i)]    <= fetch_pc_if[i*DATA_LEN +: DATA_LEN];
      end
    end
  end

  a_fetch_contig: assert property (@(posedge clk_free_master) disable iff (global_rst)
    (fetch_rdy && (|fetch_val_if)) |-> fetch_contig);

endmodule

// File: tb/tb_id_instr_queue.sv
module tb_id_instr_queue;

  localparam int FW = 4;
  localparam int IW = 2;
  localparam int DL = 32;
  localparam int DEPTH = 16;

  logic                 clk;
  logic                 global_rst;
  logic                 flush;
  logic [FW-1:0]        fetch_val_if;
  logic [FW*DL-1:0]     fetch_instr_if;
  logic [FW*DL-1:0]     fetch_pc_if;
  logic                 fetch_rdy;
  logic                 issue_stall;
  logic [IW-1:0]        instr_val_id;
  logic [IW*DL-1:0]     instr_id;
  logic [IW*DL-1:0]     pc_id;
  logic [4:0]           iq_count;
  logic                 iq_empty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb_pc[$];
  logic [31:0] sb_instr[$];

  logic        t4_on = 1'b0;
  logic        rand_stall = 1'b0;
  logic        have_last;
  logic [31:0] last_pc;

  id_instr_queue #(
    .IQ_DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH_MAX(IW), .DATA_LEN(DL)
  ) dut (
    .clk_free_master(clk),
    .global_rst(global_rst),
    .flush(flush),
    .fetch_val_if(fetch_val_if),
    .fetch_instr_if(fetch_instr_if),
    .fetch_pc_if(fetch_pc_if),
    .fetch_rdy(fetch_rdy),
    .issue_stall(issue_stall),
    .instr_val_id(instr_val_id),
    .instr_id(instr_id),
    .pc_id(pc_id),
    .iq_count(iq_count),
    .iq_empty(iq_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return {pc[23:0], 8'h13};
  endfunction

  // Scoreboard monitor: sampled mid-cycle, when inputs and outputs are stable.
  always @(negedge clk) begin
    logic          exp_rdy;
    logic [IW-1:0] exp_val;
    int            sz;
    if (global_rst) begin
      sb_pc.delete();
      sb_instr.delete();
    end else begin
      sz      = sb_pc.size();
      exp_rdy = !flush && ((DEPTH - sz) >= FW);
      check("iq_count", 32'(iq_count), 32'(sz));
      check("iq_empty", 32'(iq_empty), 32'(sz == 0));
      check("fetch_rdy", 32'(fetch_rdy), 32'(exp_rdy));
      for (int i = 0; i < IW; i++) exp_val[i] = (sz > i) && !issue_stall && !flush;
      check("instr_val_id", 32'(instr_val_id), 32'(exp_val));
      if (flush) begin
        sb_pc.delete();
        sb_instr.delete();
      end else begin
        for (int i = 0; i < IW; i++) begin
          if (exp_val[i]) begin
            check("pc_lane", pc_id[i*DL +: DL], sb_pc[i]);
            check("instr_lane", instr_id[i*DL +: DL], sb_instr[i]);
          end
        end
        for (int i = 0; i < IW; i++) begin
          if (exp_val[i]) begin
            if (t4_on) begin
              if (have_last) check("t4_seq", pc_id[i*DL +: DL], last_pc + 32'd4);
              have_last = 1'b1;
              last_pc   = pc_id[i*DL +: DL];
            end
          end
        end
        if (!t4_on) have_last = 1'b0;
        for (int i = 0; i < IW; i++) begin
          if (exp_val[i]) begin
            void'(sb_pc.pop_front());
            void'(sb_instr.pop_front());
          end
        end
        if (exp_rdy && (|fetch_val_if)) begin
          for (int i = 0; i < FW; i++) begin
            if (fetch_val_if[i]) begin
              sb_pc.push_back(fetch_pc_if[i*DL +: DL]);
              sb_instr.push_back(fetch_instr_if[i*DL +: DL]);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_group(input logic [31:0] pc0, input int n);
    fetch_val_if = '0;
    for (int i = 0; i < FW; i++) begin
      if (i < n) begin
        fetch_val_if[i] = 1'b1;
        fetch_pc_if[i*DL +: DL]    = pc0 + 32'(4 * i);
        fetch_instr_if[i*DL +: DL] = mk_instr(pc0 + 32'(4 * i));
      end
    end
  endtask

  // Present a group and hold it until the queue takes it.
  task automatic send_group(input logic [31:0] pc0, input int n, output int waits);
    logic acc;
    set_group(pc0, n);
    waits = 0;
    acc   = 1'b0;
    while (!acc && waits < 64) begin
      if (rand_stall) issue_stall = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = fetch_rdy;
      waits++;
      tick();
    end
    fetch_val_if = '0;
    if (!acc) check("fetch_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int k;
    issue_stall = 1'b0;
    k = 0;
    @(negedge clk);
    while (!iq_empty && k < 100) begin
      tick();
      @(negedge clk);
      k++;
    end
    check("drain_empty", 32'(iq_empty), 32'd1);
    tick();
  endtask

  initial begin
    int w;
    int left;
    int n;
    logic [31:0] pc;

    global_rst     = 1'b1;
    flush          = 1'b0;
    issue_stall    = 1'b0;
    fetch_val_if   = '0;
    fetch_instr_if = '0;
    fetch_pc_if    = '0;

    // T1 reset
    tick();
    @(negedge clk);
    check("t1_rdy_in_reset", 32'(fetch_rdy), 32'd0);
    tick();
    global_rst = 1'b0;
    @(negedge clk);
    check("t1_count", 32'(iq_count), 32'd0);
    check("t1_empty", 32'(iq_empty), 32'd1);
    check("t1_val", 32'(instr_val_id), 32'd0);
    check("t1_rdy", 32'(fetch_rdy), 32'd1);
    tick();

    // T2 basic flow
    send_group(32'h0, 4, w);
    @(negedge clk);
    check("t2_val0", 32'(instr_val_id), 32'h3);
    check("t2_pc0", pc_id[0 +: DL], 32'h0);
    check("t2_pc1", pc_id[DL +: DL], 32'h4);
    tick();
    @(negedge clk);
    check("t2_pc2", pc_id[0 +: DL], 32'h8);
    check("t2_pc3", pc_id[DL +: DL], 32'hC);
    tick();
    @(negedge clk);
    check("t2_empty", 32'(iq_empty), 32'd1);
    tick();

    // T3 fill and backpressure
    issue_stall = 1'b1;
    for (int g = 0; g < 4; g++) begin
      send_group(32'h100 + 32'(16 * g), 4, w);
      check("t3_no_wait", 32'(w), 32'd1);
    end
    @(negedge clk);
    check("t3_full", 32'(iq_count), 32'd16);
    check("t3_rdy_low", 32'(fetch_rdy), 32'd0);
    tick();
    issue_stall = 1'b0;
    send_group(32'h140, 4, w);
    check("t3_hold_cycles", 32'(w), 32'd3);
    drain();

    // T4 wrap-around stream with random stall
    void'($urandom(32'd1234));
    t4_on      = 1'b1;
    rand_stall = 1'b1;
    pc   = 32'h1000;
    left = 40;
    while (left > 0) begin
      n = $urandom_range(1, 4);
      if (n > left) n = left;
      send_group(pc, n, w);
      pc   = pc + 32'(4 * n);
      left = left - n;
    end
    rand_stall = 1'b0;
    drain();
    check("t4_last_pc", last_pc, 32'h1000 + 32'd156);
    t4_on = 1'b0;
    tick();

    // T5 simultaneous enqueue and dequeue
    issue_stall = 1'b1;
    send_group(32'h2000, 3, w);
    issue_stall = 1'b0;
    send_group(32'h2100, 3, w);
    check("t5_wait", 32'(w), 32'd1);
    @(negedge clk);
    check("t5_count", 32'(iq_count), 32'd4);
    check("t5_lane0", pc_id[0 +: DL], 32'h2008);
    check("t5_lane1", pc_id[DL +: DL], 32'h2100);
    tick();
    drain();

    // T6 flush with a fetch group presented
    issue_stall = 1'b1;
    send_group(32'h2800, 4, w);
    send_group(32'h2810, 3, w);
    @(negedge clk);
    check("t6_count7", 32'(iq_count), 32'd7);
    tick();
    set_group(32'h2900, 4);
    flush = 1'b1;
    @(negedge clk);
    check("t6_val_flush", 32'(instr_val_id), 32'd0);
    tick();
    flush        = 1'b0;
    fetch_val_if = '0;
    issue_stall  = 1'b0;
    @(negedge clk);
    check("t6_count0", 32'(iq_count), 32'd0);
    check("t6_val0", 32'(instr_val_id), 32'd0);
    tick();
    send_group(32'h3000, 2, w);
    @(negedge clk);
    check("t6_new_lane0", pc_id[0 +: DL], 32'h3000);
    check("t6_new_val", 32'(instr_val_id), 32'h3);
    tick();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
